// File: rtl/hc_core_if.sv
// rtl/hc_core_if.sv - instruction and data memory bus of hc_core
interface hc_core_if #(
    parameter int DW = 8
) ();
    localparam int AW = 2 * DW;

    logic [AW-1:0] imem_addr;
    logic [7:0]    imem_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_rd;
    logic          mem_wr;

    modport master (
        output imem_addr,
        input  imem_data,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        output mem_rd,
        output mem_wr
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        input  mem_rd,
        input  mem_wr
    );
endinterface

// File: rtl/hc_core.sv
// rtl/hc_core.sv - two-cycle stack-machine core with DMA bus hold
module hc_core #(
    parameter int          DW       = 8,
    parameter int          SD       = 3,
    parameter logic [63:0] RESET_PC = 64'd0,
    localparam int         AW       = 2 * DW,
    localparam int         LW       = $clog2(SD + 1)
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          nDMA_REQ,
    output logic          nDMA_ACK,
    hc_core_if.master     bus,
    output logic [AW-1:0] pc_out,
    output logic [DW-1:0] stackA_out,
    output logic [DW-1:0] stackB_out,
    output logic [DW-1:0] stackC_out,
    output logic [LW-1:0] stack_level,
    output logic          stack_ovf,
    output logic          flag_c,
    output logic          flag_z
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_pc;
    logic [7:0]    r_ir;
    logic [DW-1:0] r_stk [SD];
    logic [LW-1:0] r_level;
    logic          r_ovf;
    logic          r_c;
    logic          r_z;

    logic [3:0]    w_op;
    logic [3:0]    w_n;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [DW-1:0] w_c;
    logic [AW-1:0] w_short;
    logic [AW-1:0] w_ba;
    logic [AW-1:0] w_pc_inc;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;
    logic          w_cond;

    logic          w_mem_rd;
    logic          w_mem_wr;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic          w_push;
    logic [DW-1:0] w_push_val;
    logic [AW-1:0] w_pc_nxt;
    logic          w_upd_c;
    logic          w_c_nxt;
    logic          w_ls;
    logic          w_jl;

    assign w_op     = r_ir[7:4];
    assign w_n      = r_ir[3:0];
    assign w_a      = r_stk[0];
    assign w_b      = r_stk[1];
    assign w_c      = r_stk[2];
    assign w_short  = {{(AW-4){1'b0}}, w_n};
    assign w_ba     = {w_b, w_a};
    assign w_pc_inc = r_pc + AW'(1);
    assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
    // Subtract is A + ~B + 1 so the carry out is the "no borrow" flag.
    assign w_diff   = {1'b0, w_a} + {1'b0, ~w_b} + (DW+1)'(1);

    // State register; reset may land in any state, including EXEC or HOLD.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencing: the DMA request only matters at the end of EXEC or while holding.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: w_state_nxt = ST_EXEC;
            ST_EXEC:  w_state_nxt = nDMA_REQ ? ST_FETCH : ST_HOLD;
            ST_HOLD:  w_state_nxt = nDMA_REQ ? ST_FETCH : ST_HOLD;
            default:  w_state_nxt = ST_FETCH;
        endcase
    end

    // Jump condition on the flags as they stood before this instruction.
    always_comb begin
        w_cond = 1'b0;
        case (w_n[2:0])
            3'd0:    w_cond = 1'b1;
            3'd2:    w_cond = r_c;
            3'd3:    w_cond = ~r_c;
            3'd4:    w_cond = r_z;
            3'd5:    w_cond = ~r_z;
            default: w_cond = 1'b0;
        endcase
    end

    // Instruction decode; everything is quiet outside EXEC.
    always_comb begin
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_push      = 1'b0;
        w_push_val  = '0;
        w_pc_nxt    = w_pc_inc;
        w_upd_c     = 1'b0;
        w_c_nxt     = r_c;
        w_ls        = 1'b0;
        w_jl        = 1'b0;
        if (r_state == ST_EXEC) begin
            case (w_op)
                4'h0: begin
                    w_mem_wr    = 1'b1;
                    w_mem_addr  = w_short;
                    w_mem_wdata = w_c;
                end
                4'h1: begin
                    w_mem_wr    = 1'b1;
                    w_mem_addr  = w_short;
                    w_mem_wdata = w_a;
                end
                4'h2: begin
                    w_mem_wr    = 1'b1;
                    w_mem_addr  = w_short;
                    w_mem_wdata = w_diff[DW-1:0];
                    w_upd_c     = 1'b1;
                    w_c_nxt     = w_diff[DW];
                end
                4'h3: begin
                    w_mem_wr    = 1'b1;
                    w_mem_addr  = w_short;
                    w_mem_wdata = w_sum[DW-1:0];
                    w_upd_c     = 1'b1;
                    w_c_nxt     = w_sum[DW];
                end
                4'h4: begin
                    w_mem_wr    = 1'b1;
                    w_mem_addr  = w_short;
                    w_mem_wdata = w_a ^ w_b;
                end
                4'h5: begin
                    w_mem_wr    = 1'b1;
                    w_mem_addr  = w_short;
                    w_mem_wdata = w_a | w_b;
                end
                4'h6: begin
                    w_mem_wr    = 1'b1;
                    w_mem_addr  = w_short;
                    w_mem_wdata = w_a & w_b;
                end
                4'h8: begin
                    w_mem_rd   = 1'b1;
                    w_mem_addr = w_ba;
                    w_push     = 1'b1;
                    w_push_val = bus.mem_rdata;
                end
                4'h9: begin
                    w_mem_rd   = 1'b1;
                    w_mem_addr = w_short;
                    w_push     = 1'b1;
                    w_push_val = bus.mem_rdata;
                end
                4'hA: begin
                    w_push     = 1'b1;
                    w_push_val = {w_a[DW-1:4], w_n};
                end
                4'hC: w_ls = 1'b1;
                4'hE: begin
                    if (w_cond) begin
                        w_pc_nxt = w_ba;
                    end
                end
                4'hF: begin
                    w_jl     = 1'b1;
                    w_pc_nxt = w_ba;
                end
                default: ;
            endcase
        end
    end

    // Architectural state: IR loads in FETCH, everything else commits at the end of EXEC.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_pc    <= RESET_PC[AW-1:0];
            r_ir    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            for (int k = 0; k < SD; k++) begin
                r_stk[k] <= '0;
            end
        end else begin
            if (r_state == ST_FETCH) begin
                r_ir <= bus.imem_data;
            end
            if (r_state == ST_EXEC) begin
                r_pc <= w_pc_nxt;
                if (w_mem_wr) begin
                    r_z <= (w_mem_wdata == '0);
                end
                if (w_upd_c) begin
                    r_c <= w_c_nxt;
                end
                if (w_push) begin
                    for (int k = SD - 1; k > 0; k--) begin
                        r_stk[k] <= r_stk[k-1];
                    end
                    r_stk[0] <= w_push_val;
                    if (r_level == LW'(SD)) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_level <= r_level + LW'(1);
                    end
                end else if (w_ls) begin
                    r_stk[0] <= {w_a[DW-5:0], w_n};
                end else if (w_jl) begin
                    r_stk[0] <= w_pc_inc[DW-1:0];
                    r_stk[1] <= w_pc_inc[AW-1:DW];
                end
            end
        end
    end

    assign nDMA_ACK      = (r_state != ST_HOLD);
    assign bus.imem_addr = r_pc;
    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    assign pc_out      = r_pc;
    assign stackA_out  = r_stk[0];
    assign stackB_out  = r_stk[1];
    assign stackC_out  = r_stk[2];
    assign stack_level = r_level;
    assign stack_ovf   = r_ovf;
    assign flag_c      = r_c;
    assign flag_z      = r_z;

endmodule

// File: tb/tb_hc_core.sv
// tb/tb_hc_core.sv - randomized and directed check of hc_core against an instruction-level model
module tb_hc_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nReset;
    logic req0, req1;
    logic ack0, ack1;

    logic [15:0] pc0;
    logic [7:0]  a0, b0, c0;
    logic [1:0]  lv0;
    logic        ovf0, fc0, fz0;
    logic [31:0] pc1;
    logic [15:0] a1, b1, c1;
    logic [2:0]  lv1;
    logic        ovf1, fc1, fz1;

    logic [7:0]  imem [2][65536];
    logic [15:0] dmem [2][256];

    hc_core_if #(.DW(8))  bus0 ();
    hc_core_if #(.DW(16)) bus1 ();

    assign bus0.imem_data = imem[0][bus0.imem_addr[15:0]];
    assign bus0.mem_rdata = dmem[0][bus0.mem_addr[7:0]][7:0];
    assign bus1.imem_data = imem[1][bus1.imem_addr[15:0]];
    assign bus1.mem_rdata = dmem[1][bus1.mem_addr[7:0]];

    hc_core #(.DW(8), .SD(3), .RESET_PC(64'd0)) u0 (
        .clk(clk), .nReset(nReset), .nDMA_REQ(req0), .nDMA_ACK(ack0), .bus(bus0.master),
        .pc_out(pc0), .stackA_out(a0), .stackB_out(b0), .stackC_out(c0),
        .stack_level(lv0), .stack_ovf(ovf0), .flag_c(fc0), .flag_z(fz0)
    );

    hc_core #(.DW(16), .SD(4), .RESET_PC(64'h100)) u1 (
        .clk(clk), .nReset(nReset), .nDMA_REQ(req1), .nDMA_ACK(ack1), .bus(bus1.master),
        .pc_out(pc1), .stackA_out(a1), .stackB_out(b1), .stackC_out(c1),
        .stack_level(lv1), .stack_ovf(ovf1), .flag_c(fc1), .flag_z(fz1)
    );

    // Instruction-level model, one slot per instance. Phase: 0 fetch, 1 exec, 2 hold.
    logic [31:0] m_pc  [2];
    logic [7:0]  m_ir  [2];
    logic [15:0] m_stk [2][4];
    int          m_lvl [2];
    bit          m_ovf [2];
    bit          m_c   [2];
    bit          m_z   [2];
    int          m_ph  [2];
    logic [15:0] mm    [2][256];

    int total = 0;
    int bad   = 0;

    function automatic int dw(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    function automatic int sd(input int i);
        return (i == 0) ? 3 : 4;
    endfunction

    function automatic logic [31:0] rpc(input int i);
        return (i == 0) ? 32'h0 : 32'h100;
    endfunction

    function automatic logic [63:0] msk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_pc[i]  = rpc(i);
        m_ir[i]  = 8'h00;
        for (int k = 0; k < 4; k++) m_stk[i][k] = 16'h0;
        m_lvl[i] = 0;
        m_ovf[i] = 1'b0;
        m_c[i]   = 1'b0;
        m_z[i]   = 1'b0;
        m_ph[i]  = 0;
    endtask

    task automatic push(input int i, input logic [15:0] v);
        if (m_lvl[i] == sd(i)) m_ovf[i] = 1'b1;
        else m_lvl[i]++;
        for (int k = sd(i) - 1; k > 0; k--) m_stk[i][k] = m_stk[i][k-1];
        m_stk[i][0] = v;
    endtask

    // Memory strobes the current instruction must show while in EXEC.
    task automatic exp_bus(input int i, output bit rd, output bit wr,
                           output logic [31:0] ad, output logic [15:0] wd);
        logic [63:0] m, a, b, c, r;
        int op, n, w;
        rd = 1'b0; wr = 1'b0; ad = 32'h0; wd = 16'h0;
        if (m_ph[i] == 1) begin
            w  = dw(i);
            m  = msk(w);
            a  = 64'(m_stk[i][0]);
            b  = 64'(m_stk[i][1]);
            c  = 64'(m_stk[i][2]);
            op = int'(m_ir[i][7:4]);
            n  = int'(m_ir[i][3:0]);
            r  = 64'h0;
            if (op <= 6) begin
                wr = 1'b1;
                ad = 32'(n);
                case (op)
                    0: r = c;
                    1: r = a;
                    2: r = (a + (~b & m) + 64'd1) & m;
                    3: r = (a + b) & m;
                    4: r = a ^ b;
                    5: r = a | b;
                    default: r = a & b;
                endcase
                wd = 16'(r);
            end else if (op == 8) begin
                rd = 1'b1;
                ad = 32'((b << w) | a);
            end else if (op == 9) begin
                rd = 1'b1;
                ad = 32'(n);
            end
        end
    endtask

    function automatic bit taken(input int i, input int n);
        case (n & 7)
            0: return 1'b1;
            2: return m_c[i];
            3: return !m_c[i];
            4: return m_z[i];
            5: return !m_z[i];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_exec(input int i);
        logic [63:0] m, ma, a, b, pc, npc, t;
        bit rd, wr;
        logic [31:0] ad;
        logic [15:0] wd;
        int op, n, w;
        w   = dw(i);
        m   = msk(w);
        ma  = msk(2 * w);
        a   = 64'(m_stk[i][0]);
        b   = 64'(m_stk[i][1]);
        pc  = 64'(m_pc[i]);
        npc = (pc + 64'd1) & ma;
        op  = int'(m_ir[i][7:4]);
        n   = int'(m_ir[i][3:0]);
        exp_bus(i, rd, wr, ad, wd);
        if (wr) begin
            mm[i][ad[7:0]] = wd;
            m_z[i] = (wd == 16'h0);
        end
        case (op)
            2: m_c[i] = (((a + (~b & m) + 64'd1) >> w) & 64'd1) != 64'd0;
            3: m_c[i] = (((a + b) >> w) & 64'd1) != 64'd0;
            8, 9: push(i, mm[i][ad[7:0]]);
            10: push(i, 16'((a & m & ~64'hF) | 64'(n)));
            12: m_stk[i][0] = 16'(((a << 4) | 64'(n)) & m);
            14: if (taken(i, n)) npc = (b << w) | a;
            15: begin
                npc = (b << w) | a;
                t   = (pc + 64'd1) & ma;
                m_stk[i][0] = 16'(t & m);
                m_stk[i][1] = 16'(t >> w);
            end
            default: ;
        endcase
        m_pc[i] = 32'(npc);
    endtask

    task automatic model_step(input int i, input logic req);
        case (m_ph[i])
            0: begin
                m_ir[i] = imem[i][m_pc[i][15:0]];
                m_ph[i] = 1;
            end
            1: begin
                model_exec(i);
                m_ph[i] = req ? 0 : 2;
            end
            default: if (req) m_ph[i] = 0;
        endcase
    endtask

    task automatic check_inst(input int i);
        logic [31:0] pc, ia, sa, sb, sc, lv, ad, wd, ead;
        logic        ov, fc, fz, ak, rd, wr;
        bit          erd, ewr;
        logic [15:0] ewd;
        if (i == 0) begin
            pc = 32'(pc0); ia = 32'(bus0.imem_addr);
            sa = 32'(a0); sb = 32'(b0); sc = 32'(c0); lv = 32'(lv0);
            ov = ovf0; fc = fc0; fz = fz0; ak = ack0;
            rd = bus0.mem_rd; wr = bus0.mem_wr;
            ad = 32'(bus0.mem_addr); wd = 32'(bus0.mem_wdata);
        end else begin
            pc = pc1; ia = bus1.imem_addr;
            sa = 32'(a1); sb = 32'(b1); sc = 32'(c1); lv = 32'(lv1);
            ov = ovf1; fc = fc1; fz = fz1; ak = ack1;
            rd = bus1.mem_rd; wr = bus1.mem_wr;
            ad = bus1.mem_addr; wd = 32'(bus1.mem_wdata);
        end
        exp_bus(i, erd, ewr, ead, ewd);
        chk($sformatf("u%0d pc", i), pc, m_pc[i]);
        chk($sformatf("u%0d imem_addr", i), ia, m_pc[i]);
        chk($sformatf("u%0d stackA", i), sa, 32'(m_stk[i][0]));
        chk($sformatf("u%0d stackB", i), sb, 32'(m_stk[i][1]));
        chk($sformatf("u%0d stackC", i), sc, 32'(m_stk[i][2]));
        chk($sformatf("u%0d level", i), lv, 32'(m_lvl[i]));
        chk($sformatf("u%0d ovf", i), 32'(ov), 32'(m_ovf[i]));
        chk($sformatf("u%0d flag_c", i), 32'(fc), 32'(m_c[i]));
        chk($sformatf("u%0d flag_z", i), 32'(fz), 32'(m_z[i]));
        chk($sformatf("u%0d ack", i), 32'(ak), 32'(m_ph[i] != 2));
        chk($sformatf("u%0d mem_rd", i), 32'(rd), 32'(erd));
        chk($sformatf("u%0d mem_wr", i), 32'(wr), 32'(ewr));
        chk($sformatf("u%0d mem_addr", i), ad, ead);
        chk($sformatf("u%0d mem_wdata", i), wd, 32'(ewd));
    endtask

    // One clock: drive at the falling edge, compare, then advance DUT memory and model.
    task automatic tick(input logic rst, input logic r0, input logic r1);
        logic        wr_s [2];
        logic [7:0]  ad_s [2];
        logic [15:0] wd_s [2];
        @(negedge clk);
        nReset = rst;
        req0   = r0;
        req1   = r1;
        if (!rst) begin
            model_reset(0);
            model_reset(1);
        end
        #1;
        check_inst(0);
        check_inst(1);
        wr_s[0] = bus0.mem_wr; ad_s[0] = bus0.mem_addr[7:0]; wd_s[0] = 16'(bus0.mem_wdata);
        wr_s[1] = bus1.mem_wr; ad_s[1] = bus1.mem_addr[7:0]; wd_s[1] = bus1.mem_wdata;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (wr_s[i] === 1'b1) dmem[i][ad_s[i]] = wd_s[i];
        end
        if (rst) begin
            model_step(0, r0);
            model_step(1, r1);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b1, 1'b1);
    endtask

    task automatic set_dmem(input int i, input int a, input logic [15:0] v);
        dmem[i][a] = v;
        mm[i][a]   = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 65536; a++) imem[i][a] = 8'h70;
            for (int a = 0; a < 256; a++) set_dmem(i, a, 16'h0);
        end
    endtask

    task automatic put(input int i, input logic [31:0] a, input logic [7:0] v);
        imem[i][a[15:0]] = v;
    endtask

    // Holds reset for one clock and loads the same program at both reset vectors.
    task automatic start_seg(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                             input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                             input logic [7:0] p6);
        logic [7:0] prog [7];
        tick(1'b0, 1'b1, 1'b1);
        clear_mem();
        prog = '{p0, p1, p2, p3, p4, p5, p6};
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 7; k++) put(i, rpc(i) + 32'(k), prog[k]);
    endtask

    initial begin
        nReset = 1'b0;
        req0   = 1'b1;
        req1   = 1'b1;
        model_reset(0);
        model_reset(1);
        clear_mem();

        // Reset state and add/subtract/flag-jump sequence.
        start_seg(8'hA5, 8'hA3, 8'h32, 8'hA1, 8'hA1, 8'h24, 8'hE4);
        #1;
        chk("reset pc", 32'(pc0), 32'h0);
        chk("reset level", 32'(lv0), 32'h0);
        chk("reset ack", 32'(ack0), 32'h1);
        chk("reset pc u1", pc1, 32'h100);
        for (int i = 0; i < 2; i++) begin
            set_dmem(i, 2, 16'h00AA);
            set_dmem(i, 4, 16'h0055);
        end
        run(6);
        #1;
        chk("add mem2", 32'(dmem[0][2]), 32'h08);
        chk("add model mem2", 32'(mm[0][2]), 32'h08);
        chk("add mem2 u1", 32'(dmem[1][2]), 32'h0008);
        chk("add flag_c", 32'(fc0), 32'h0);
        chk("add flag_z", 32'(fz0), 32'h0);
        run(8);
        #1;
        chk("su mem4", 32'(dmem[0][4]), 32'h00);
        chk("su flag_z", 32'(fz0), 32'h1);
        chk("su flag_c", 32'(fc0), 32'h1);
        chk("jz pc", 32'(pc0), 32'h0101);
        chk("jz model pc", m_pc[0], 32'h0101);
        chk("jz pc u1", pc1, 32'h00010001);

        // Stack depth saturation and overflow.
        start_seg(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h70, 8'h70, 8'h70);
        run(6);
        #1;
        chk("three push level", 32'(lv0), 32'h3);
        chk("three push ovf", 32'(ovf0), 32'h0);
        run(2);
        #1;
        chk("ovf A", 32'(a0), 32'h4);
        chk("ovf B", 32'(b0), 32'h3);
        chk("ovf C", 32'(c0), 32'h2);
        chk("ovf level", 32'(lv0), 32'h3);
        chk("ovf flag", 32'(ovf0), 32'h1);
        chk("u1 level", 32'(lv1), 32'h4);
        chk("u1 ovf", 32'(ovf1), 32'h0);

        // Jump-and-link from 0x12FE.
        start_seg(8'hA1, 8'hC2, 8'hAF, 8'hCC, 8'hE0, 8'h70, 8'h70);
        put(0, 32'h12FC, 8'h95);
        put(0, 32'h12FD, 8'h96);
        put(0, 32'h12FE, 8'hF0);
        set_dmem(0, 5, 16'h00);
        set_dmem(0, 6, 16'h40);
        run(10);
        #1;
        chk("jp pc", 32'(pc0), 32'h12FC);
        run(4);
        #1;
        chk("pre jl pc", 32'(pc0), 32'h12FE);
        chk("pre jl A", 32'(a0), 32'h40);
        chk("pre jl B", 32'(b0), 32'h00);
        run(2);
        #1;
        chk("jl pc", 32'(pc0), 32'h0040);
        chk("jl A", 32'(a0), 32'hFF);
        chk("jl B", 32'(b0), 32'h12);

        // Program counter wrap.
        start_seg(8'hAF, 8'hCF, 8'hAF, 8'hE0, 8'h70, 8'h70, 8'h70);
        run(8);
        #1;
        chk("wrap top pc", 32'(pc0), 32'hFFFF);
        run(2);
        #1;
        chk("wrap pc", 32'(pc0), 32'h0000);

        // DMA request raised during the fetch of AD.
        start_seg(8'hA5, 8'hA3, 8'h32, 8'hA1, 8'h70, 8'h70, 8'h70);
        run(4);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        #1;
        chk("dma ack", 32'(ack0), 32'h0);
        chk("dma pc", 32'(pc0), 32'h3);
        chk("dma mem_wr", 32'(bus0.mem_wr), 32'h0);
        chk("dma add done", 32'(dmem[0][2]), 32'h08);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        #1;
        chk("dma release ack", 32'(ack0), 32'h1);
        chk("dma release pc", 32'(pc0), 32'h3);
        run(4);

        // Reset asserted in the middle of the AD store.
        start_seg(8'hA5, 8'hA3, 8'h32, 8'h70, 8'h70, 8'h70, 8'h70);
        run(5);
        @(negedge clk);
        #1;
        chk("store wr", 32'(bus0.mem_wr), 32'h1);
        chk("store wdata", 32'(bus0.mem_wdata), 32'h08);
        chk("store wdata u1", 32'(bus1.mem_wdata), 32'h0008);
        nReset = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        chk("rst wr", 32'(bus0.mem_wr), 32'h0);
        chk("rst pc", 32'(pc0), 32'h0);
        chk("rst pc u1", pc1, 32'h100);
        tick(1'b0, 1'b1, 1'b1);
        run(6);

        // Random programs, data, DMA traffic and occasional resets.
        tick(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 65536; a++) imem[i][a] = 8'($urandom);
            for (int a = 0; a < 256; a++) set_dmem(i, a, 16'($urandom) & 16'(msk(dw(i))));
        end
        for (int k = 0; k < 4000; k++) begin
            tick(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hc_core.md
HC_CORE -- requirements
Module: hc_core

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data/stack word width (legal: 8..32).
REQ-002 SHALL have parameter SD, default 3, meaning stack depth in words (legal: >=3).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-004 SHALL derive AW = 2*DW (address width) and LW = clog2(SD+1).
REQ-005 clk  in  1  single system clock; all state updates on rising edge.
REQ-006 nReset  in  1  asynchronous, active-low reset.
REQ-007 nDMA_REQ  in  1  active-low bus request from DMA master.
REQ-008 nDMA_ACK  out  1  active-low bus grant; low only while core is in HOLD.
REQ-009 imem_addr  out  AW  instruction fetch address (= pc).
REQ-010 imem_data  in  8  instruction byte, combinational response to imem_addr.
REQ-011 mem_addr, mem_wdata, mem_rdata  out/out/in  AW/DW/DW  data memory address, write data, combinational read data.
REQ-012 mem_rd, mem_wr  out  1  active-high read/write strobes, asserted for the whole EXEC cycle only.
REQ-013 pc_out  out  AW; stackA_out, stackB_out, stackC_out  out  DW; stack_level  out  LW; stack_ovf  out  1; flag_c, flag_z  out  1.

Function
REQ-014 SHALL run FSM FETCH -> EXEC -> FETCH; FETCH latches imem_data into IR at cycle end; EXEC executes IR and updates pc at cycle end (2 clocks per instruction).
REQ-015 Opcode IR[7:4], nibble n = IR[3:0]; short address = n zero-extended to AW.
REQ-016 Stores, mem_wr=1, mem_addr = short address, Z <= (wdata==0): 0000 SC (wdata=C), 0001 SA (wdata=A), 0010 SU (A+~B+1, C <= carry out), 0011 AD (A+B, C <= carry out), 0100 XR, 0101 OR, 0110 AN (wdata=A op B, C unchanged); 0111 NOP.
REQ-017 Loads, mem_rd=1, push mem_rdata: 1000 LD [AB] (mem_addr = {B,A}), 1001 LD n (mem_addr = short address).
REQ-018 1010 LI: push {A[DW-1:4], n}; 1100 LS: A <= {A[DW-5:0], n}, no push; 1011, 1101 NOP.
REQ-019 1110 Jcc on n[2:0]: 000 JP, 001 NP, 010 JC, 011 JNC, 100 JZ, 101 JNZ, 110/111 NP; taken -> pc <= {B,A}, else pc+1; flags read are values before this EXEC.
REQ-020 1111 JL: pc <= {B,A}; A <= (pc+1)[DW-1:0], B <= (pc+1)[AW-1:DW] using pre-jump values; deeper entries unchanged.
REQ-021 Push: entry[k] <= entry[k-1] for k=1..SD-1, entry[0] <= new; entry[SD-1] lost; A/B/C = entry[0..2].
REQ-022 stack_level SHALL increment per push, saturate at SD; a push at SD SHALL set stack_ovf (sticky until reset).
REQ-023 pc SHALL wrap from 2^AW-1 to 0; additions are modulo 2^DW / 2^AW.
REQ-024 Outside EXEC, and for non-memory opcodes, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-025 nDMA_REQ SHALL be sampled only at end of EXEC; if low, next state HOLD, else FETCH.
REQ-026 In HOLD: nDMA_ACK=0, all mem_* outputs 0, all architectural state frozen; HOLD -> FETCH at the edge where nDMA_REQ is sampled high, nDMA_ACK=1 from that edge.
REQ-027 nDMA_REQ low during FETCH SHALL NOT abort the current instruction.

Reset
REQ-028 nReset low SHALL immediately force: state FETCH, pc=RESET_PC, IR=0, all stack entries 0, stack_level=0, stack_ovf=0, flags 0, nDMA_ACK=1, mem_rd=mem_wr=0, regardless of state (incl. mid-EXEC or HOLD).
REQ-029 First fetch SHALL occur in the first clock after nReset deasserts.

Verification
REQ-030 DW=8: LI 5, LI 3, AD 2 -> mem[2] written 0x08 during EXEC, flag_c=0, flag_z=0.
REQ-031 A=0x01,B=0x01: SU 4 -> wdata 0x00, flag_z=1, flag_c=1; then JZ -> pc=0x0101.
REQ-032 SD=3: four LI pushes (1,2,3,4) -> A=4,B=3,C=2, stack_level=3, stack_ovf=1.
REQ-033 JL at pc=0x12FE with {B,A}=0x0040 -> pc=0x0040, A=0xFF, B=0x12.
REQ-034 nDMA_REQ low during FETCH of AD -> AD completes, nDMA_ACK low next cycle, mem_* 0, state frozen; release -> fetch resumes at pc+1.
REQ-035 nReset pulsed low mid-EXEC of a store -> mem_wr drops at once, pc=RESET_PC; DW=16 variant repeats REQ-030 with 16-bit results.
